// File: rtl/rv_pkg.sv
// Shared constants for the RV64 integer core: default widths, the zero register
// and ABI register indices.
package rv_pkg;

    localparam int XLEN_DEF = 64;
    localparam int NREG_DEF = 32;
    localparam int REG_ZERO = 0;

    // ABI names for the integer register indices
    localparam int RA  = 1;
    localparam int SP  = 2;
    localparam int GP  = 3;
    localparam int TP  = 4;
    localparam int T0  = 5;
    localparam int T1  = 6;
    localparam int T2  = 7;
    localparam int S0  = 8;
    localparam int S1  = 9;
    localparam int A0  = 10;
    localparam int A1  = 11;
    localparam int A2  = 12;
    localparam int A3  = 13;
    localparam int A4  = 14;
    localparam int A5  = 15;

endpackage

// File: rtl/rv_sb.sv
// Issue scoreboard: one busy bit per architectural register plus a running count
// of busy registers. Register 0 can never become busy.
module rv_sb
    import rv_pkg::*;
#(
    parameter int  NREG = NREG_DEF,
    localparam int AW   = $clog2(NREG)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            iss_en_i,
    input  logic [AW-1:0]   iss_addr_i,
    input  logic            wr_en_i,
    input  logic [AW-1:0]   wr_addr_i,
    output logic [NREG-1:0] busy_o,
    output logic [AW-1:0]   busy_cnt_o
);

    logic [NREG-1:0] busy_q, busy_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic            iss_v, wr_v, set_new, clr_new;

    always_comb begin
        iss_v   = iss_en_i && (iss_addr_i != AW'(REG_ZERO));
        wr_v    = wr_en_i && (wr_addr_i != AW'(REG_ZERO));
        set_new = iss_v && !busy_q[iss_addr_i];
        // A writeback to the register being re-issued this cycle leaves it busy.
        clr_new = wr_v && busy_q[wr_addr_i] && !(iss_v && (iss_addr_i == wr_addr_i));
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        if (flush_i) begin
            busy_d = '0;
            cnt_d  = '0;
        end else begin
            if (wr_v) busy_d[wr_addr_i] = 1'b0;
            if (iss_v) busy_d[iss_addr_i] = 1'b1;
            cnt_d = cnt_q + AW'(set_new) - AW'(clr_new);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_o     = busy_q;
    assign busy_cnt_o = cnt_q;

endmodule

// File: rtl/rv_rf_sb.sv
// Integer register file with NRD combinational read ports, one clocked writeback
// port, optional write-to-read bypass and an integrated issue scoreboard.
module rv_rf_sb
    import rv_pkg::*;
#(
    parameter int  XLEN   = XLEN_DEF,
    parameter int  NREG   = NREG_DEF,
    parameter int  NRD    = 2,
    parameter int  BYPASS = 1,
    localparam int AW     = $clog2(NREG)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NRD*AW-1:0]   rd_addr_i,
    output logic [NRD*XLEN-1:0] rd_data_o,
    output logic [NRD-1:0]      rd_busy_o,
    input  logic                wr_en_i,
    input  logic [AW-1:0]       wr_addr_i,
    input  logic [XLEN-1:0]     wr_data_i,
    input  logic                iss_en_i,
    input  logic [AW-1:0]       iss_addr_i,
    input  logic                flush_i,
    output logic [AW-1:0]       busy_cnt_o
);

    // wr_en_i and iss_en_i are valid-only strobes with no ready: every strobe
    // seen at a rising edge is accepted on that edge, nothing is ever back-pressured.

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [NREG-1:0] busy;
    logic            wr_v;

    rv_sb #(.NREG(NREG)) u_sb (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .flush_i    (flush_i),
        .iss_en_i   (iss_en_i),
        .iss_addr_i (iss_addr_i),
        .wr_en_i    (wr_en_i),
        .wr_addr_i  (wr_addr_i),
        .busy_o     (busy),
        .busy_cnt_o (busy_cnt_o)
    );

    always_comb begin
        wr_v   = wr_en_i && (wr_addr_i != AW'(REG_ZERO));
        regs_d = regs_q;
        if (wr_v) regs_d[wr_addr_i] = wr_data_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    // Reads are forced to zero / not-busy while reset is held, independent of the clock.
    always_comb begin
        logic [AW-1:0] ra;
        logic          hit;
        rd_data_o = '0;
        rd_busy_o = '0;
        for (int k = 0; k < NRD; k++) begin
            ra  = rd_addr_i[k*AW +: AW];
            hit = (BYPASS != 0) && wr_en_i && (wr_addr_i == ra);
            if (!rst_i && (ra != AW'(REG_ZERO))) begin
                rd_data_o[k*XLEN +: XLEN] = hit ? wr_data_i : regs_q[ra];
                rd_busy_o[k]              = busy[ra] && !hit;
            end
        end
    end

endmodule
